// File: rtl/picomem_dma_pkg.sv
// picomem_dma shared definitions: register map, CTRL bits, FSM states.
// Fill mode is built in only when PICOMEM_DMA_FILL_EN is defined.
package picomem_dma_pkg;

  localparam logic [2:0] REG_SRC  = 3'd0;
  localparam logic [2:0] REG_DST  = 3'd1;
  localparam logic [2:0] REG_LEN  = 3'd2;
  localparam logic [2:0] REG_CTRL = 3'd3;
  localparam logic [2:0] REG_FILL = 3'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_FILL  = 3;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FIN
  } dma_state_e;

  function automatic logic [31:0] wstrb_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/picomem_dma_regs.sv
// picomem_dma register file and cfg responder with BUSY write-lock.
// FILL / FILL_DATA exist only when PICOMEM_DMA_FILL_EN is defined.
module picomem_dma_regs
  import picomem_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [31:0]      cfg_addr_i,
  input  logic [31:0]      cfg_wdata_i,
  input  logic [3:0]       cfg_wstrb_i,
  output logic [31:0]      cfg_rdata_o,
  input  logic             busy_i,
  input  logic             done_set_i,
  input  logic             cnt_we_i,
  input  logic [31:0]      src_nxt_i,
  input  logic [31:0]      dst_nxt_i,
  input  logic [LEN_W-1:0] len_nxt_i,
  output logic [31:0]      src_o,
  output logic [31:0]      dst_o,
  output logic [LEN_W-1:0] len_o,
  output logic             start_o,
`ifdef PICOMEM_DMA_FILL_EN
  output logic             fill_o,
  output logic [31:0]      fill_data_o,
`endif
  output logic             done_o
);

  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
`ifdef PICOMEM_DMA_FILL_EN
  logic             fill_q, fill_d;
  logic [31:0]      fdata_q, fdata_d;
`endif

  logic        acc;
  logic        wr;
  logic [2:0]  sel;
  logic [31:0] len_m;
  logic [31:0] stat;
  logic        unused_bits;

  assign acc = cfg_valid_i & ~ready_q;
  assign wr  = acc & (|cfg_wstrb_i);
  assign sel = cfg_addr_i[4:2];

  assign len_m = wstrb_merge(32'(len_q), cfg_wdata_i, cfg_wstrb_i);

  assign unused_bits = ^{cfg_addr_i[31:5], cfg_addr_i[1:0],
                         len_m[31:LEN_W]};

  always_comb begin
    stat = '0;
    stat[CTRL_BUSY] = busy_i;
    stat[CTRL_DONE] = done_q;
`ifdef PICOMEM_DMA_FILL_EN
    stat[CTRL_FILL] = fill_q;
`else
    stat[CTRL_FILL] = 1'b0;
`endif
  end

  always_comb begin
    ready_d = acc;
    rdata_d = '0;
    start_d = 1'b0;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    done_d  = done_q;
`ifdef PICOMEM_DMA_FILL_EN
    fill_d  = fill_q;
    fdata_d = fdata_q;
`endif

    if (acc) begin
      case (sel)
        REG_SRC:  rdata_d = src_q;
        REG_DST:  rdata_d = dst_q;
        REG_LEN:  rdata_d = 32'(len_q);
        REG_CTRL: rdata_d = stat;
`ifdef PICOMEM_DMA_FILL_EN
        REG_FILL: rdata_d = fdata_q;
`else
        REG_FILL: rdata_d = '0;
`endif
        default:  rdata_d = '0;
      endcase
    end

    // Shadow registers are frozen while a copy is running
    if (wr && !busy_i) begin
      case (sel)
        REG_SRC: src_d = wstrb_merge(src_q, cfg_wdata_i,
                                     cfg_wstrb_i) & ~32'd3;
        REG_DST: dst_d = wstrb_merge(dst_q, cfg_wdata_i,
                                     cfg_wstrb_i) & ~32'd3;
        REG_LEN: len_d = len_m[LEN_W-1:0];
`ifdef PICOMEM_DMA_FILL_EN
        REG_FILL: fdata_d = wstrb_merge(fdata_q, cfg_wdata_i,
                                        cfg_wstrb_i);
`endif
        default: ;
      endcase
    end

    if (wr && sel == REG_CTRL && cfg_wstrb_i[0]) begin
      if (cfg_wdata_i[CTRL_DONE]) done_d = 1'b0;
      if (!busy_i) begin
        start_d = cfg_wdata_i[CTRL_START];
`ifdef PICOMEM_DMA_FILL_EN
        fill_d  = cfg_wdata_i[CTRL_FILL];
`endif
      end
    end

    if (cnt_we_i) begin
      src_d = src_nxt_i;
      dst_d = dst_nxt_i;
      len_d = len_nxt_i;
    end

    if (done_set_i) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef PICOMEM_DMA_FILL_EN
      fill_q  <= 1'b0;
      fdata_q <= '0;
`endif
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      start_q <= start_d;
      done_q  <= done_d;
`ifdef PICOMEM_DMA_FILL_EN
      fill_q  <= fill_d;
      fdata_q <= fdata_d;
`endif
    end
  end

  assign cfg_ready_o = ready_q;
  assign cfg_rdata_o = rdata_q;
  assign src_o       = src_q;
  assign dst_o       = dst_q;
  assign len_o       = len_q;
  assign start_o     = start_q;
  assign done_o      = done_q;
`ifdef PICOMEM_DMA_FILL_EN
  assign fill_o      = fill_q;
  assign fill_data_o = fdata_q;
`endif

endmodule

// File: rtl/picomem_dma.sv
// picomem_dma top: copy FSM, initiator beat registers, counter writeback.
// Fill mode (write-only beats) is enabled by PICOMEM_DMA_FILL_EN.
module picomem_dma
  import picomem_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic [3:0]  cfg_wstrb,
  output logic [31:0] cfg_rdata,
  output logic        dma_valid,
  input  logic        dma_ready,
  output logic [31:0] dma_addr,
  output logic [31:0] dma_wdata,
  output logic [3:0]  dma_wstrb,
  input  logic [31:0] dma_rdata,
  output logic        irq_done
);

  dma_state_e state_q, state_d;

  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] data_q, data_d;

  logic [31:0]      src, dst;
  logic [LEN_W-1:0] len;
  logic             start, busy, done_set, cnt_we;
  logic [31:0]      src_nxt, dst_nxt;
  logic [LEN_W-1:0] len_nxt;

  logic        fill_mode;
  logic [31:0] fill_word;

`ifdef PICOMEM_DMA_FILL_EN
  logic        fill;
  logic [31:0] fill_data;
  assign fill_mode = fill;
  assign fill_word = fill_data;
`else
  assign fill_mode = 1'b0;
  assign fill_word = '0;
`endif

  assign busy = (state_q != IDLE);

  picomem_dma_regs #(
    .LEN_W (LEN_W)
  ) u_regs (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_wstrb_i (cfg_wstrb),
    .cfg_rdata_o (cfg_rdata),
    .busy_i      (busy),
    .done_set_i  (done_set),
    .cnt_we_i    (cnt_we),
    .src_nxt_i   (src_nxt),
    .dst_nxt_i   (dst_nxt),
    .len_nxt_i   (len_nxt),
    .src_o       (src),
    .dst_o       (dst),
    .len_o       (len),
    .start_o     (start),
`ifdef PICOMEM_DMA_FILL_EN
    .fill_o      (fill),
    .fill_data_o (fill_data),
`endif
    .done_o      (irq_done)
  );

  // In RD/WR, valid low means the beat finished and this is the idle gap
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    data_d   = data_q;
    done_set = 1'b0;
    cnt_we   = 1'b0;
    src_nxt  = src;
    dst_nxt  = dst;
    len_nxt  = len;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = FIN;
          end else if (fill_mode) begin
            state_d = WR;
            valid_d = 1'b1;
            addr_d  = dst;
            wdata_d = fill_word;
            strb_d  = 4'hF;
          end else begin
            state_d = RD;
            valid_d = 1'b1;
            addr_d  = src;
            strb_d  = 4'h0;
          end
        end
      end
      RD: begin
        if (!valid_q) begin
          state_d = WR;
          valid_d = 1'b1;
          addr_d  = dst;
          wdata_d = data_q;
          strb_d  = 4'hF;
        end else if (dma_ready) begin
          valid_d = 1'b0;
          data_d  = dma_rdata;
        end
      end
      WR: begin
        if (valid_q) begin
          if (dma_ready) begin
            valid_d = 1'b0;
            cnt_we  = 1'b1;
            src_nxt = fill_mode ? src : src + 32'd4;
            dst_nxt = dst + 32'd4;
            len_nxt = len - LEN_W'(1);
          end
        end else if (len == '0) begin
          state_d = FIN;
        end else if (fill_mode) begin
          valid_d = 1'b1;
          addr_d  = dst;
          wdata_d = fill_word;
          strb_d  = 4'hF;
        end else begin
          state_d = RD;
          valid_d = 1'b1;
          addr_d  = src;
          strb_d  = 4'h0;
        end
      end
      FIN: begin
        done_set = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      data_q  <= data_d;
    end
  end

  assign dma_valid = valid_q;
  assign dma_addr  = addr_q;
  assign dma_wdata = wdata_q;
  assign dma_wstrb = strb_q;

endmodule
